// File: rtl/uart_io.sv
// uart_io: 8N1 fixed-baud UART on the J1 I/O bus.
// TX holding register + shifter; RX synchroniser, FSM and small FIFO.
module uart_io #(
  parameter int          CLK_FREQ = 24000000,
  parameter int          BAUD     = 115200,
  parameter logic [15:0] BASE     = 16'h4030,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  input  logic        io_wr,
  input  logic        io_rd,
  output logic [15:0] uart_din,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [15:0]   STAT = BASE + 16'd2;

  typedef enum logic [1:0] {
    T_IDLE, T_START, T_DATA, T_STOP
  } tx_st_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
  } rx_st_t;

  logic data_rd, stat_rd, data_wr;
  logic unused_hi;

  assign data_rd   = io_rd && (io_addr == BASE);
  assign stat_rd   = io_rd && (io_addr == STAT);
  assign data_wr   = io_wr && (io_addr == BASE);
  assign unused_hi = ^io_dout[15:8];

  tx_st_t          tx_st, tx_nx;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic [7:0]      tx_sh, tx_sh_n;
  logic [7:0]      hold_q;
  logic            hold_full, hold_take;
  logic            txd_n, tx_busy;

  assign tx_busy = (tx_st != T_IDLE);

  // TX next state: txd is registered from the current state, so the
  // line lags the FSM by one clock.
  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_n  = tx_cnt;
    tx_bit_n  = tx_bit;
    tx_sh_n   = tx_sh;
    hold_take = 1'b0;
    txd_n     = 1'b1;
    unique case (tx_st)
      T_IDLE: begin
        if (hold_full) begin
          tx_nx     = T_START;
          tx_sh_n   = hold_q;
          tx_cnt_n  = '0;
          hold_take = 1'b1;
        end
      end
      T_START: begin
        txd_n = 1'b0;
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_nx    = T_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      T_DATA: begin
        txd_n = tx_sh[0];
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_nx = T_STOP;
          else tx_bit_n = tx_bit + 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      T_STOP: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (hold_full) begin
            tx_nx     = T_START;
            tx_sh_n   = hold_q;
            hold_take = 1'b1;
          end else begin
            tx_nx = T_IDLE;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_nx = T_IDLE;
    endcase
  end

  // TX state, line register and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st     <= T_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      uart_txd  <= 1'b1;
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else begin
      tx_st    <= tx_nx;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      uart_txd <= txd_n;
      if (hold_take) begin
        hold_full <= 1'b0;
      end else if (data_wr && !hold_full) begin
        hold_full <= 1'b1;
        hold_q    <= io_dout[7:0];
      end
    end
  end

  logic            rx_r1, rx_s;
  rx_st_t          rx_st, rx_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_sh, rx_sh_n;
  logic            push, ferr_set;

  // RX next state: start is checked mid-bit, then every DIV clocks.
  always_comb begin
    rx_nx    = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        if (!rx_s) begin
          rx_nx    = R_START;
          rx_cnt_n = HALF;
        end
      end
      R_START: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_nx    = rx_s ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_nx = R_STOP;
          else rx_bit_n = rx_bit + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          if (rx_s) begin
            push  = 1'b1;
            rx_nx = R_IDLE;
          end else begin
            ferr_set = 1'b1;
            rx_nx    = R_WAIT;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      R_WAIT: begin
        if (rx_s) rx_nx = R_IDLE;
      end
      default: rx_nx = R_IDLE;
    endcase
  end

  // RX synchroniser and state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_r1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_r1  <= uart_rxd;
      rx_s   <= rx_r1;
      rx_st  <= rx_nx;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  logic [7:0]  mem [RX_DEPTH];
  logic [AW:0] wp, rp;
  logic        empty, full, pop, do_push, ovr_set;
  logic        ovr, ferr;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = data_rd && !empty;
  assign do_push = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= rx_sh;
  end

  // FIFO pointers and sticky flags; a set on the clearing edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp   <= '0;
      rp   <= '0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      ovr  <= ovr_set | (ovr & !stat_rd);
      ferr <= ferr_set | (ferr & !stat_rd);
    end
  end

  // Read mux; zero unless a read hits one of the two registers.
  always_comb begin
    uart_din = '0;
    unique case (1'b1)
      data_rd: uart_din = empty ? 16'h0000 : {8'h00, mem[rp[AW-1:0]]};
      stat_rd: uart_din = {11'b0, tx_busy, ferr, ovr, !empty, !hold_full};
      default: uart_din = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_io.sv
// tb_uart_io: directed bench for uart_io at DIV=8.
// Bus driven on negedges; serial lines checked on negedges.
module tb_uart_io;

  localparam logic [15:0] BASE = 16'h4030;
  localparam logic [15:0] STAT = 16'h4032;

  logic        clk, reset;
  logic [15:0] io_addr, io_dout, uart_din;
  logic        io_wr, io_rd, uart_rxd, uart_txd;
  int          passed, total;

  uart_io #(
    .CLK_FREQ(8),
    .BAUD(1),
    .BASE(BASE),
    .RX_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_addr(io_addr),
    .io_dout(io_dout),
    .io_wr(io_wr),
    .io_rd(io_rd),
    .uart_din(uart_din),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    io_addr = a;
    io_dout = d;
    io_wr   = 1'b1;
    tick();
    io_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    io_rd   = 1'b1;
    #1;
    d = uart_din;
    tick();
    io_rd = 1'b0;
  endtask

  // Expected line level t clocks after the start bit begins.
  function automatic logic line_exp(input logic [7:0] b, input int t);
    if (t < 8) return 1'b0;
    if (t < 72) return b[(t - 8) / 8];
    return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (8) tick();
    end
    uart_rxd = stop;
    repeat (8) tick();
    uart_rxd = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset;
    logic [15:0] d;
    reset = 1'b1;
    uart_rxd = 1'b1;
    io_addr = '0;
    io_dout = '0;
    io_wr = 1'b0;
    io_rd = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++;
    if (uart_txd !== 1'b1)
      $display("FAIL reset_txd: got %b, want 1", uart_txd);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL reset_status: got %h, want 0001", d);
    else passed++;
    bus_read(BASE, d);
    total++;
    if (d !== 16'h0000)
      $display("FAIL reset_data: got %h, want 0000", d);
    else passed++;
  endtask

  task automatic test_tx_frame;
    logic [15:0] d, st;
    int errs;
    bus_write(BASE, 16'h0055);
    total++;
    if (uart_txd !== 1'b1)
      $display("FAIL tx_edge0: got %b, want 1", uart_txd);
    else passed++;
    tick();
    total++;
    if (uart_txd !== 1'b1)
      $display("FAIL tx_edge1: got %b, want 1", uart_txd);
    else passed++;
    tick();
    errs = 0;
    st = '0;
    for (int t = 0; t < 80; t++) begin
      if (uart_txd !== line_exp(8'h55, t)) errs++;
      if (t == 40) begin
        io_addr = STAT;
        io_rd = 1'b1;
        #1;
        st = uart_din;
        io_rd = 1'b0;
      end
      tick();
    end
    total++;
    if (errs != 0)
      $display("FAIL tx_frame_55: got %0d bad clocks, want 0", errs);
    else passed++;
    total++;
    if (st !== 16'h0011)
      $display("FAIL tx_status_busy: got %h, want 0011", st);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL tx_status_idle: got %h, want 0001", d);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d, st1, st2;
    logic exp;
    int errs;
    bus_write(BASE, 16'h00A5);
    tick();
    tick();
    errs = 0;
    st1 = '0;
    st2 = '0;
    for (int t = 0; t < 160; t++) begin
      if (t == 11) io_wr = 1'b0;
      exp = (t < 80) ? line_exp(8'hA5, t) : line_exp(8'h3C, t - 80);
      if (uart_txd !== exp) errs++;
      if (t == 10) begin
        io_addr = BASE;
        io_dout = 16'h003C;
        io_wr = 1'b1;
      end
      if (t == 50 || t == 85) begin
        io_addr = STAT;
        io_rd = 1'b1;
        #1;
        if (t == 50) st1 = uart_din;
        else st2 = uart_din;
        io_rd = 1'b0;
      end
      tick();
    end
    total++;
    if (errs != 0)
      $display("FAIL b2b_frames: got %0d bad clocks, want 0", errs);
    else passed++;
    total++;
    if (st1 !== 16'h0010)
      $display("FAIL b2b_hold_full: got %h, want 0010", st1);
    else passed++;
    total++;
    if (st2 !== 16'h0011)
      $display("FAIL b2b_hold_moved: got %h, want 0011", st2);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL b2b_idle: got %h, want 0001", d);
    else passed++;
  endtask

  task automatic test_rx_fifo;
    logic [15:0] d;
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0007)
      $display("FAIL rx_overrun_set: got %h, want 0007", d);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0003)
      $display("FAIL rx_overrun_clr: got %h, want 0003", d);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      bus_read(BASE, d);
      total++;
      if (d !== 16'(i))
        $display("FAIL rx_pop%0d: got %h, want %h", i, d, 16'(i));
      else passed++;
    end
    bus_read(BASE, d);
    total++;
    if (d !== 16'h0000)
      $display("FAIL rx_pop_empty: got %h, want 0000", d);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL rx_drained: got %h, want 0001", d);
    else passed++;
  endtask

  task automatic test_frame_err;
    logic [15:0] d;
    send_rx(8'h7E, 1'b0);
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0009)
      $display("FAIL ferr_set: got %h, want 0009", d);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL ferr_clr: got %h, want 0001", d);
    else passed++;
    bus_read(BASE, d);
    total++;
    if (d !== 16'h0000)
      $display("FAIL ferr_discard: got %h, want 0000", d);
    else passed++;
  endtask

  task automatic test_glitch;
    logic [15:0] d;
    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL glitch_status: got %h, want 0001", d);
    else passed++;
    bus_read(BASE, d);
    total++;
    if (d !== 16'h0000)
      $display("FAIL glitch_data: got %h, want 0000", d);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    for (int c = 0; c < 55; c++) begin
      uart_rxd = line_exp(8'hA5, c);
      if (c == 20) begin
        io_addr = BASE;
        io_dout = 16'h0007;
        io_wr = 1'b1;
      end
      if (c == 21) io_wr = 1'b0;
      tick();
    end
    uart_rxd = line_exp(8'hA5, 55);
    total++;
    if (uart_txd !== 1'b0)
      $display("FAIL mid_tx_bit3: got %b, want 0", uart_txd);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (uart_txd !== 1'b1)
      $display("FAIL mid_txd_reset: got %b, want 1", uart_txd);
    else passed++;
    reset = 1'b0;
    uart_rxd = 1'b1;
    tick();
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL mid_status: got %h, want 0001", d);
    else passed++;
    send_rx(8'h42, 1'b1);
    bus_read(BASE, d);
    total++;
    if (d !== 16'h0042)
      $display("FAIL mid_rx_42: got %h, want 0042", d);
    else passed++;
    bus_read(STAT, d);
    total++;
    if (d !== 16'h0001)
      $display("FAIL mid_final: got %h, want 0001", d);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rx_fifo();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
